// File: rtl/q_next_max_scanner.sv
// Max-Q row scanner.
// Reads every action entry of one Q-table row through a single synchronous
// read port. Returns the largest signed Q-value and the lowest action index
// that holds it. Requests and results each use a valid/ready handshake.
module q_next_max_scanner #(
  parameter int DATA_W      = 32,
  parameter int STATE_W     = 8,
  parameter int NUM_ACTIONS = 4,
  parameter int ACT_W       = $clog2(NUM_ACTIONS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [STATE_W-1:0]         req_state,
  output logic                       mem_rd_en,
  output logic [STATE_W+ACT_W-1:0]   mem_rd_addr,
  input  logic [DATA_W-1:0]          mem_rd_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          max_q,
  output logic [ACT_W-1:0]           max_action
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [ACT_W-1:0] LAST_ACT = ACT_W'(NUM_ACTIONS - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [ACT_W-1:0]     r_k;
  logic [STATE_W-1:0]   r_lat_state;
  logic                 r_rd_en_d;
  logic [ACT_W-1:0]     r_k_d;
  logic [DATA_W-1:0]    r_run_max;
  logic [ACT_W-1:0]     r_run_arg;
  logic [DATA_W-1:0]    r_max_q;
  logic [ACT_W-1:0]     r_max_action;

  logic                 w_req_ready;
  logic                 w_rd_en;
  logic                 w_out_valid;
  logic                 w_accept;
  logic [DATA_W-1:0]    w_cmp_max;
  logic [ACT_W-1:0]     w_cmp_arg;

  // State register; reset aborts any scan in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and handshake/strobe outputs.
  always_comb begin
    w_state_next = r_state;
    w_req_ready  = 1'b0;
    w_rd_en      = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = ~rst;
        if (req_valid) begin
          w_state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        w_rd_en = 1'b1;
        if (r_k == LAST_ACT) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_state_next = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_accept = w_req_ready & req_valid;

  // Running-max candidate: the first datum of a row always loads, later ones
  // only win on a strictly greater signed value so ties keep the lower index.
  always_comb begin
    w_cmp_max = r_run_max;
    w_cmp_arg = r_run_arg;
    if (r_rd_en_d) begin
      if ((r_k_d == '0) || ($signed(mem_rd_data) > $signed(r_run_max))) begin
        w_cmp_max = mem_rd_data;
        w_cmp_arg = r_k_d;
      end
    end
  end

  // Action counter, latched state and the one-cycle delayed read tag that
  // lines up with the RAM's read latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k         <= '0;
      r_lat_state <= '0;
      r_rd_en_d   <= 1'b0;
      r_k_d       <= '0;
    end else begin
      r_rd_en_d <= w_rd_en;
      r_k_d     <= r_k;
      if (w_accept) begin
        r_lat_state <= req_state;
        r_k         <= '0;
      end else if (w_rd_en) begin
        r_k <= r_k + ACT_W'(1);
      end
    end
  end

  // Running max tracks the compare stage; the result is captured as the last
  // datum is consumed in DRAIN and held through DONE and beyond.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_max    <= '0;
      r_run_arg    <= '0;
      r_max_q      <= '0;
      r_max_action <= '0;
    end else begin
      if (r_rd_en_d) begin
        r_run_max <= w_cmp_max;
        r_run_arg <= w_cmp_arg;
      end
      if (r_state == S_DRAIN) begin
        r_max_q      <= w_cmp_max;
        r_max_action <= w_cmp_arg;
      end
    end
  end

  assign req_ready   = w_req_ready;
  assign mem_rd_en   = w_rd_en;
  assign mem_rd_addr = w_rd_en ? {r_lat_state, r_k} : '0;
  assign out_valid   = w_out_valid;
  assign max_q       = r_max_q;
  assign max_action  = r_max_action;

endmodule

// File: tb/tb_q_next_max_scanner.sv
// Testbench for q_next_max_scanner: Q-table RAM model, expected-result
// scoreboard filled on request accept and drained on result handshake.
module tb_q_next_max_scanner;

  localparam int DW = 32;
  localparam int SW = 8;
  localparam int NA = 4;
  localparam int AW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [SW-1:0]     req_state;
  logic              mem_rd_en;
  logic [SW+AW-1:0]  mem_rd_addr;
  logic [DW-1:0]     mem_rd_data;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     max_q;
  logic [AW-1:0]     max_action;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [DW-1:0]    qmem [0:(1<<(SW+AW))-1];
  logic [AW+DW-1:0] sb [$];
  logic [SW+AW-1:0] addr_q [$];
  int               rise_cyc = 0;
  logic             prev_ov = 1'b0;

  q_next_max_scanner #(
    .DATA_W(DW), .STATE_W(SW), .NUM_ACTIONS(NA), .ACT_W(AW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_state(req_state),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .max_q(max_q), .max_action(max_action)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: one-cycle read latency, junk on the bus when not reading.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= qmem[mem_rd_addr];
    else           mem_rd_data <= $urandom();
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: signed max over the row, first occurrence wins.
  function automatic logic [AW+DW-1:0] model(input int s);
    logic signed [DW-1:0] best;
    logic [AW-1:0]        arg;
    logic signed [DW-1:0] v;
    best = qmem[s*NA];
    arg  = '0;
    for (int a = 1; a < NA; a++) begin
      v = qmem[s*NA + a];
      if (v > best) begin
        best = v;
        arg  = AW'(a);
      end
    end
    return {arg, best};
  endfunction

  task automatic set_row(input int s, input logic [DW-1:0] a0, a1, a2, a3);
    qmem[s*NA+0] = a0;
    qmem[s*NA+1] = a1;
    qmem[s*NA+2] = a2;
    qmem[s*NA+3] = a3;
  endtask

  // Monitor: read addresses, out_valid rise time, result scoreboard.
  always @(negedge clk) begin
    logic [AW+DW-1:0] e;
    if (mem_rd_en) addr_q.push_back(mem_rd_addr);
    if (out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = out_valid;
    if (out_valid && out_ready) begin
      check("sb_nonempty", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("max_q", max_q, e[DW-1:0]);
        check("max_action", max_action, e[AW+DW-1:DW]);
        $display("[TB] result max_q=%0d max_action=%0d", $signed(max_q), max_action);
      end
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic start_req(input int s, output int acc, output int waits);
    req_valid = 1'b1;
    req_state = SW'(s);
    waits = 0;
    do begin
      @(negedge clk);
      waits++;
    end while (!req_ready && waits < 100);
    check("req_accept", req_ready, 1'b1);
    acc = cyc;
    sb.push_back(model(s));
    $display("[TB] request state=%0d accepted at cycle %0d", s, acc);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_state = SW'($urandom());
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc, acc2, w, n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_state = '0;
    out_ready = 1'b1;
    for (int i = 0; i < (1<<(SW+AW)); i++) qmem[i] = $urandom();
    set_row(5, 10, 40, 25, 3);
    set_row(7, -7, -2, -9, 32'h8000_0000);
    set_row(8, 8, 8, 3, 8);
    set_row(9, 5, -1, 100, 100);
    set_row(6, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
    set_row(1, 1, 2, 3, 4);
    set_row(2, 50, -50, 49, 7);
    set_row(3, 9, 9, 9, 99);
    set_row(4, -100, -3, -3, -50);

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_rd_en", mem_rd_en, 1'b0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_max_q", max_q, 0);
    check("rst_max_action", max_action, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", req_ready, 1'b1);
    @(posedge clk); #1;

    // Basic row, address sequence and latency
    addr_q.delete();
    start_req(5, acc, w);
    wait_done();
    check("addr_count", addr_q.size(), 4);
    for (int i = 0; i < 4 && i < addr_q.size(); i++) check("addr_seq", addr_q[i], 20 + i);
    check("latency", rise_cyc - acc, 6);

    // Signed compare and tie-break
    start_req(7, acc, w);
    wait_done();
    start_req(8, acc, w);
    wait_done();

    // Backpressure with a held request behind it
    out_ready = 1'b0;
    start_req(9, acc, w);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 50);
    check("bp_valid_seen", out_valid, 1'b1);
    req_valid = 1'b1;
    req_state = 8'd6;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_max_q", max_q, 100);
      check("bp_max_action", max_action, 2);
      check("bp_req_ready", req_ready, 1'b0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    start_req(6, acc, w);
    check("held_accept_delay", w, 2);
    wait_done();

    // Back-to-back throughput
    start_req(1, acc, w);
    start_req(2, acc2, w);
    check("b2b_spacing", acc2 - acc, NA + 3);
    wait_done();

    // Reset in the second SCAN cycle
    start_req(3, acc, w);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("abort_rd_en", mem_rd_en, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_req_ready", req_ready, 1'b0);
    check("abort_max_q", max_q, 0);
    sb.delete();
    repeat (2) begin
      @(negedge clk);
      check("abort_hold_rd_en", mem_rd_en, 1'b0);
      check("abort_hold_valid", out_valid, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", req_ready, 1'b1);
    check("post_rst_valid", out_valid, 1'b0);
    @(posedge clk); #1;
    addr_q.delete();
    start_req(4, acc, w);
    wait_done();
    check("post_rst_addr_count", addr_q.size(), 4);
    if (addr_q.size() > 0) check("post_rst_addr0", addr_q[0], 16);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/q_next_max_scanner.md
Name: q_next_max_scanner

Overview:
- Upstream stage of the Q-value update datapath; produces the max_next_q operand for the update stage.
- Given a next-state index, reads all NUM_ACTIONS Q-values of that state's row from the Q-table RAM through a single synchronous read port.
- Returns the maximum Q-value and the action index that holds it, via valid/ready handshakes on both request and result sides.

Parameters:
- DATA_W, 32, Q-value width; signed two's complement.
- STATE_W, 8, state index width.
- NUM_ACTIONS, 4, actions per state; must be at least 2 and a power of two.
- ACT_W, $clog2(NUM_ACTIONS), action index width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request.
- req_state  input  STATE_W  next-state index; sampled on request handshake.
- mem_rd_en  output  1  Q-table read strobe.
- mem_rd_addr  output  STATE_W+ACT_W  read address = {state, action}.
- mem_rd_data  input  DATA_W  read data; valid exactly 1 cycle after mem_rd_en.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- max_q  output  DATA_W  maximum Q-value of the row.
- max_action  output  ACT_W  lowest action index holding max_q.

Behaviour:
- Reset: FSM goes to IDLE.
  - Outputs under reset: req_ready=0 while rst is asserted, then 1 in IDLE. mem_rd_en=0, mem_rd_addr=0, out_valid=0, max_q=0, max_action=0.
  - Internal counters and registers clear to 0.
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: latch req_state, clear the action counter, go to SCAN.
- SCAN: NUM_ACTIONS cycles, counter k=0..NUM_ACTIONS-1.
  - mem_rd_en=1 and mem_rd_addr={latched_state,k} every cycle.
  - Go to DRAIN after k=NUM_ACTIONS-1.
  - mem_rd_en is never asserted outside SCAN.
- Compare stage: uses a 1-cycle delayed copy of rd_en and k.
  - When the delayed rd_en=1 and delayed k=0: load running max from mem_rd_data, running arg=0.
  - When the delayed rd_en=1 and k>0: replace only if mem_rd_data > running max (signed compare). Ties keep the earlier (lower) index.
- DRAIN: one cycle that consumes the last read datum. Then go to DONE; max_q and max_action are registered on this transition.
- DONE:
  - out_valid=1; max_q and max_action are stable and held until out_ready=1.
  - On out_valid&&out_ready: go to IDLE next cycle, out_valid=0. max_q and max_action keep their last values.
- Latency: request accepted at edge E0 → mem_rd_en high in cycles 1..NUM_ACTIONS → out_valid high from cycle NUM_ACTIONS+2. With the default this is 6 cycles.
- Throughput: one request per NUM_ACTIONS+3 cycles minimum (out_ready held high).
- req_ready=0 in SCAN, DRAIN and DONE. A new request is never accepted in the same cycle as the result handshake.
- mem_rd_data is ignored in any cycle not following a mem_rd_en.
- Signed extremes: the most negative value 0x80000000 is a legal Q-value. An all-negative row returns the least negative entry.
- req_state changes after the handshake have no effect on the scan in progress.
- rst asserted mid-SCAN/DRAIN/DONE: the operation aborts immediately. All outputs return to reset values, with no partial result and no further mem_rd_en.
- out_ready held high before out_valid has no effect.

Test Plan:
- Reset, then req_state=5 with row {10,40,25,3} and out_ready=1:
  - mem_rd_addr sequence 20,21,22,23 on consecutive cycles.
  - out_valid 6 cycles after accept, max_q=40, max_action=1.
- Row {-7,-2,-9,0x80000000}: max_q=0xFFFFFFFE (-2), max_action=1. This confirms the signed compare.
- Tie row {8,8,3,8}: max_q=8, max_action=0.
- Backpressure: out_ready=0 for 10 cycles after out_valid.
  - max_q, max_action and out_valid stay stable; req_ready stays 0.
  - A held req_valid is not accepted until the cycle after out_ready=1.
- Back-to-back: two requests (states 1 and 2) with out_ready=1.
  - Second accept occurs exactly NUM_ACTIONS+3 cycles after the first.
  - Each result matches its own row.
- rst pulsed during the 2nd SCAN cycle:
  - mem_rd_en drops asynchronously, out_valid stays 0, req_ready=1 after release.
  - The next request completes correctly.
